// File: rtl/instruction_decoder_if.sv
// Decode-stage bus: fetch inputs, write-back port, fetch stall/redirect and the registered issue bundle.
interface instruction_decoder_if;
    logic [31:0] InstructionFetched;
    logic [31:0] ProgramCounter;
    logic        EX_StallReq;
    logic        WB_WriteEnable;
    logic [3:0]  WB_WriteReg;
    logic [31:0] WB_WriteData;
    logic        IF_StallReq;
    logic        BranchSelection;
    logic [31:0] BranchAddress;
    logic        ValidOut;
    logic [3:0]  OpcodeOut;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic [31:0] StoreData;
    logic [3:0]  DestReg;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        IllegalOp;

    modport master (
        output InstructionFetched, ProgramCounter, EX_StallReq,
               WB_WriteEnable, WB_WriteReg, WB_WriteData,
        input  IF_StallReq, BranchSelection, BranchAddress,
               ValidOut, OpcodeOut, OperandA, OperandB, StoreData,
               DestReg, RegWrite, MemRead, MemWrite, IllegalOp
    );

    modport slave (
        input  InstructionFetched, ProgramCounter, EX_StallReq,
               WB_WriteEnable, WB_WriteReg, WB_WriteData,
        output IF_StallReq, BranchSelection, BranchAddress,
               ValidOut, OpcodeOut, OperandA, OperandB, StoreData,
               DestReg, RegWrite, MemRead, MemWrite, IllegalOp
    );
endinterface

// File: rtl/instruction_decoder.sv
// Decode stage: field decode, 16x32 register file, pending-write scoreboard, branch redirect, registered issue.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle write-back into register reads and hazard checks.
module instruction_decoder #(
    parameter logic [31:0] REGFILE_RESET_VALUE = 32'h0
) (
    input logic ClockInput,
    input logic ResetInput,
    instruction_decoder_if.slave bus
);
    localparam logic [3:0] OpAdd  = 4'd1;
    localparam logic [3:0] OpAddi = 4'd2;
    localparam logic [3:0] OpSub  = 4'd3;
    localparam logic [3:0] OpBeq  = 4'd4;
    localparam logic [3:0] OpJmp  = 4'd5;
    localparam logic [3:0] OpLw   = 4'd6;
    localparam logic [3:0] OpSw   = 4'd7;

    typedef struct packed {
        logic        valid;
        logic [3:0]  opcode;
        logic [31:0] operandA;
        logic [31:0] operandB;
        logic [31:0] storeData;
        logic [3:0]  destReg;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic        illegalOp;
    } issueT;

    logic [31:0] regFile [16];
    logic [15:0] pending;
    issueT       issueQ;
    issueT       decoded;

    logic [3:0]  opcode, rd, rs, rt;
    logic [15:0] imm;
    logic [31:0] immSext;

    assign opcode  = bus.InstructionFetched[31:28];
    assign rd      = bus.InstructionFetched[27:24];
    assign rs      = bus.InstructionFetched[23:20];
    assign rt      = bus.InstructionFetched[19:16];
    assign imm     = bus.InstructionFetched[15:0];
    assign immSext = {{16{imm[15]}}, imm};

    logic [15:0] wbHit;
    logic [15:0] pendingEff;
    assign wbHit = bus.WB_WriteEnable ? (16'd1 << bus.WB_WriteReg) : 16'd0;

    logic [31:0] readPort [16];
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            readPort[i] = regFile[i];
`ifdef DECODE_WB_BYPASS_EN
            if (wbHit[i]) readPort[i] = bus.WB_WriteData;
`endif
        end
        readPort[0] = 32'd0;
    end

`ifdef DECODE_WB_BYPASS_EN
    assign pendingEff = pending & ~wbHit;
`else
    assign pendingEff = pending;
`endif

    logic [31:0] rdVal, rsVal, rtVal;
    logic        useRs, useRt, useRd, writesRd;
    assign rdVal = readPort[rd];
    assign rsVal = readPort[rs];
    assign rtVal = readPort[rt];

    always_comb begin
        useRs   = 1'b0;
        useRt   = 1'b0;
        useRd   = 1'b0;
        decoded = '0;
        decoded.valid = 1'b1;
        case (opcode)
            OpAdd, OpSub: begin
                useRs = 1'b1;
                useRt = 1'b1;
                decoded.operandB = rtVal;
            end
            OpAddi, OpLw: begin
                useRs = 1'b1;
                decoded.operandB = immSext;
            end
            OpBeq: begin
                useRd = 1'b1;
                useRs = 1'b1;
            end
            OpSw: begin
                useRs = 1'b1;
                useRd = 1'b1;
                decoded.operandB  = immSext;
                decoded.storeData = rdVal;
            end
            default: ;
        endcase
        writesRd = (opcode inside {OpAdd, OpAddi, OpSub, OpLw}) && (rd != 4'd0);
        // upper half of the opcode space goes out as a flagged NOP
        if (opcode[3]) begin
            decoded.illegalOp = 1'b1;
        end else begin
            decoded.opcode   = opcode;
            decoded.operandA = rsVal;
        end
        decoded.destReg  = writesRd ? rd : 4'd0;
        decoded.regWrite = writesRd;
        decoded.memRead  = (opcode == OpLw);
        decoded.memWrite = (opcode == OpSw);
    end

    logic [15:0] srcMask;
    logic        hazard, taken;
    assign srcMask = (useRs ? (16'd1 << rs) : 16'd0)
                   | (useRt ? (16'd1 << rt) : 16'd0)
                   | ((useRd || writesRd) ? (16'd1 << rd) : 16'd0);
    assign hazard  = |(pendingEff & srcMask);

    assign bus.IF_StallReq     = hazard | bus.EX_StallReq;
    assign taken               = (opcode == OpJmp) || ((opcode == OpBeq) && (rdVal == rsVal));
    assign bus.BranchSelection = taken & ~bus.IF_StallReq;
    assign bus.BranchAddress   = !bus.BranchSelection ? 32'd0
                               : (opcode == OpJmp) ? {16'd0, imm}
                               : bus.ProgramCounter + immSext;

    always_ff @(posedge ClockInput or posedge ResetInput) begin
        if (ResetInput) begin
            for (int i = 0; i < 16; i++) regFile[i] <= (i == 0) ? 32'd0 : REGFILE_RESET_VALUE;
            pending <= '0;
            issueQ  <= '0;
        end else begin
            if (bus.WB_WriteEnable && (bus.WB_WriteReg != 4'd0))
                regFile[bus.WB_WriteReg] <= bus.WB_WriteData;
            // set is OR'd in after the clear so a same-edge issue keeps its destination pending
            pending <= (pending & ~wbHit)
                     | ((writesRd && !bus.IF_StallReq) ? (16'd1 << rd) : 16'd0);
            if (!bus.EX_StallReq)
                issueQ <= hazard ? '0 : decoded;
        end
    end

    assign bus.ValidOut  = issueQ.valid;
    assign bus.OpcodeOut = issueQ.opcode;
    assign bus.OperandA  = issueQ.operandA;
    assign bus.OperandB  = issueQ.operandB;
    assign bus.StoreData = issueQ.storeData;
    assign bus.DestReg   = issueQ.destReg;
    assign bus.RegWrite  = issueQ.regWrite;
    assign bus.MemRead   = issueQ.memRead;
    assign bus.MemWrite  = issueQ.memWrite;
    assign bus.IllegalOp = issueQ.illegalOp;
endmodule
